// File: rtl/photon_gate_counter.sv
// photon_gate_counter: counts synchronized photon rises per 50Hz sync window and offers each count on valid/ready.
// Define PERIOD_MEASURE_EN to also report the window length in clk cycles on period_cycles.
module photon_gate_counter #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int PER_W       = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             photon_pulse,
  input  logic             sync_50Hz,
  output logic [CNT_W-1:0] count_data,
  output logic             count_sat,
  output logic             count_valid,
  input  logic             count_ready,
  output logic             overrun,
  output logic [PER_W-1:0] period_cycles
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES:0] ph_sync_q, ph_sync_d, sy_sync_q, sy_sync_d;
  logic ph_rise_q, ph_rise_d, sy_rise_q, sy_rise_d;
  logic [CNT_W-1:0] acc_q, acc_d, data_q, data_d;
  logic sat_q, sat_d, csat_q, csat_d, valid_q, valid_d, overrun_q, overrun_d;

  // Top bit of each chain is the previous value of the last synchronizer stage.
  always_comb begin
    ph_sync_d = {ph_sync_q[SYNC_STAGES-1:0], photon_pulse};
    sy_sync_d = {sy_sync_q[SYNC_STAGES-1:0], sync_50Hz};
    ph_rise_d = ph_sync_q[SYNC_STAGES-1] & ~ph_sync_q[SYNC_STAGES];
    sy_rise_d = sy_sync_q[SYNC_STAGES-1] & ~sy_sync_q[SYNC_STAGES];
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    data_d    = data_q;
    csat_d    = csat_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && count_ready) valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        sat_d = 1'b0;
        if (enable && sy_rise_q) state_d = COUNT;
      end
      COUNT: begin
        if (!enable) begin
          state_d = IDLE;
          acc_d   = '0;
          sat_d   = 1'b0;
        end else if (sy_rise_q) begin
          // A photon coincident with the close belongs to the new window.
          data_d    = acc_q;
          csat_d    = sat_q;
          valid_d   = 1'b1;
          overrun_d = valid_q && !count_ready;
          acc_d     = CNT_W'(ph_rise_q);
          sat_d     = 1'b0;
        end else if (ph_rise_q && (acc_q != '1)) begin
          acc_d = acc_q + 1'b1;
          if (acc_d == '1) sat_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ph_sync_q <= '0;
      sy_sync_q <= '0;
      ph_rise_q <= 1'b0;
      sy_rise_q <= 1'b0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      data_q    <= '0;
      csat_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_sync_q <= ph_sync_d;
      sy_sync_q <= sy_sync_d;
      ph_rise_q <= ph_rise_d;
      sy_rise_q <= sy_rise_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      data_q    <= data_d;
      csat_q    <= csat_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign count_data  = data_q;
  assign count_sat   = csat_q;
  assign count_valid = valid_q;
  assign overrun     = overrun_q;

`ifdef PERIOD_MEASURE_EN
  logic win_clear, win_close;
  logic [PER_W-1:0] per_acc_q, per_acc_d, period_q, period_d;

  assign win_clear = (state_q == IDLE) || !enable;
  assign win_close = (state_q == COUNT) && enable && sy_rise_q;

  // Reported length includes the closing sync cycle itself.
  always_comb begin
    per_acc_d = per_acc_q;
    period_d  = period_q;
    if (win_clear) begin
      per_acc_d = '0;
    end else if (win_close) begin
      period_d  = (per_acc_q == '1) ? per_acc_q : per_acc_q + 1'b1;
      per_acc_d = '0;
    end else if (per_acc_q != '1) begin
      per_acc_d = per_acc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      per_acc_q <= '0;
      period_q  <= '0;
    end else begin
      per_acc_q <= per_acc_d;
      period_q  <= period_d;
    end
  end

  assign period_cycles = period_q;
`else
  assign period_cycles = '0;
`endif

endmodule
